// File: rtl/canvas_pkg.sv
// canvas_pkg: shared constants, color codes, state type and command struct for
// the framebuffer writers that feed pixelStore.
//   CANVAS_DIM  canvas width/height in pixels (coordinates 0..CANVAS_DIM-1)
//   COORD_W     coordinate width, matches pixelStore wx/wy
//   COLOR_W     color code width
//   RAD_W       brush radius width
package canvas_pkg;
   localparam int CANVAS_DIM = 128;
   localparam int COORD_W    = 8;
   localparam int COLOR_W    = 3;
   localparam int RAD_W      = 3;

   localparam logic [COORD_W-1:0] COORD_MAX = COORD_W'(CANVAS_DIM - 1);

   // Color codes shared with pixelStore; erase is the background color.
   localparam logic [COLOR_W-1:0] COL_ERASE = 3'd0;
   localparam logic [COLOR_W-1:0] COL_RED   = 3'd1;
   localparam logic [COLOR_W-1:0] COL_GREEN = 3'd2;
   localparam logic [COLOR_W-1:0] COL_BLUE  = 3'd3;
   localparam logic [COLOR_W-1:0] COL_WHITE = 3'd7;

   typedef enum logic [1:0] {IDLE, STAMP, CLEAR} stamp_state_t;

   typedef struct packed {
      logic               clear;
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
      logic [COLOR_W-1:0] color;
      logic [RAD_W-1:0]   radius;
   } stamp_cmd_t;
endpackage

// File: rtl/brush_span_clip.sv
// brush_span_clip: combinational clip of one axis of a square brush.
//   c      in   centre coordinate (unsigned)
//   r      in   brush half-width
//   lo,hi  out  clipped span [max(c-r,0), min(c+r,CANVAS_DIM-1)]
//   empty  out  span lies entirely off-canvas (lo > hi)
module brush_span_clip
   import canvas_pkg::*;
(
   input  logic [COORD_W-1:0] c,
   input  logic [RAD_W-1:0]   r,
   output logic [COORD_W-1:0] lo,
   output logic [COORD_W-1:0] hi,
   output logic               empty
);
   // Two extra bits: one so c+r cannot overflow, one for the sign of c-r.
   localparam int SW = COORD_W + 2;
   localparam logic signed [SW-1:0] MAX_S = SW'(CANVAS_DIM - 1);

   logic signed [SW-1:0] cs, rs, lo_raw, hi_raw, lo_s, hi_s;

   always_comb begin
      cs     = signed'({2'b00, c});
      rs     = signed'({{(SW-RAD_W){1'b0}}, r});
      lo_raw = cs - rs;
      hi_raw = cs + rs;
      lo_s   = (lo_raw < 0) ? '0 : lo_raw;
      hi_s   = (hi_raw > MAX_S) ? MAX_S : hi_raw;
      empty  = lo_s > hi_s;
      lo     = lo_s[COORD_W-1:0];
      hi     = hi_s[COORD_W-1:0];
   end
endmodule

// File: rtl/brush_stamper.sv
// brush_stamper: expands stamp/clear commands into a one-pixel-per-cycle
// write stream for pixelStore.
//   clk, reset              clock, async active-high reset
//   cmd_valid/cmd_ready     command handshake (ready only in IDLE)
//   cmd_clear               1 = clear whole canvas to erase
//   cmd_x/y/color/radius    stamp centre, color and half-width
//   brush, wx, wy, newColor registered write strobe, coordinates, color
//   busy                    ~cmd_ready
module brush_stamper
   import canvas_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic               cmd_clear,
   input  logic [COORD_W-1:0] cmd_x,
   input  logic [COORD_W-1:0] cmd_y,
   input  logic [COLOR_W-1:0] cmd_color,
   input  logic [RAD_W-1:0]   cmd_radius,
   output logic               brush,
   output logic [COORD_W-1:0] wx,
   output logic [COORD_W-1:0] wy,
   output logic [COLOR_W-1:0] newColor,
   output logic               busy
);
   stamp_state_t state;
   stamp_cmd_t   cmd;

   // Axis 0 = x, axis 1 = y.
   logic [1:0][COORD_W-1:0] ax_c, ax_lo, ax_hi;
   logic [1:0]              ax_empty;

   // Captured scan window; ylo is only needed at accept, so it is not kept.
   logic [COORD_W-1:0] xlo, xhi, yhi;
   logic               at_xhi, at_end;

   assign cmd     = '{clear: cmd_clear, x: cmd_x, y: cmd_y, color: cmd_color, radius: cmd_radius};
   assign ax_c[0] = cmd.x;
   assign ax_c[1] = cmd.y;

   for (genvar a = 0; a < 2; a++) begin : g_axis
      brush_span_clip u_clip (
         .c     (ax_c[a]),
         .r     (cmd.radius),
         .lo    (ax_lo[a]),
         .hi    (ax_hi[a]),
         .empty (ax_empty[a])
      );
   end

   assign cmd_ready = (state == IDLE);
   assign busy      = ~cmd_ready;
   assign at_xhi    = (wx == xhi);
   assign at_end    = at_xhi && (wy == yhi);

   // wx/wy are both the output registers and the scan counters: the pixel
   // being presented is the scan position.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         brush    <= 1'b0;
         wx       <= '0;
         wy       <= '0;
         newColor <= COL_ERASE;
         xlo      <= '0;
         xhi      <= '0;
         yhi      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  if (cmd.clear) begin
                     state    <= CLEAR;
                     xlo      <= '0;
                     xhi      <= COORD_MAX;
                     yhi      <= COORD_MAX;
                     wx       <= '0;
                     wy       <= '0;
                     newColor <= COL_ERASE;
                     brush    <= 1'b1;
                  end else begin
                     state <= STAMP;
                     xlo   <= ax_lo[0];
                     xhi   <= ax_hi[0];
                     yhi   <= ax_hi[1];
                     // A null stamp spends one busy cycle with brush low and
                     // leaves the write outputs untouched.
                     if (!(|ax_empty)) begin
                        wx       <= ax_lo[0];
                        wy       <= ax_lo[1];
                        newColor <= cmd.color;
                        brush    <= 1'b1;
                     end
                  end
               end
            end
            STAMP, CLEAR: begin
               if (!brush || at_end) begin
                  brush <= 1'b0;
                  state <= IDLE;
               end else if (at_xhi) begin
                  wx <= xlo;
                  wy <= wy + 1'b1;
               end else begin
                  wx <= wx + 1'b1;
               end
            end
            default: begin
               brush <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_brush_stamper.sv
module tb_brush_stamper;
   import canvas_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       cmd_valid, cmd_ready, cmd_clear;
   logic [7:0] cmd_x, cmd_y, wx, wy;
   logic [2:0] cmd_color, cmd_radius, newColor;
   logic       brush, busy;

   int checks   = 0;
   int failures = 0;

   brush_stamper dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_clear(cmd_clear), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_color(cmd_color),
      .cmd_radius(cmd_radius), .brush(brush), .wx(wx), .wy(wy),
      .newColor(newColor), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Present a command and return just after the accepting edge.
   task automatic send(input bit clr, input int x, input int y, input int r, input int col);
      int w = 0;
      cmd_clear  = clr;
      cmd_x      = 8'(x);
      cmd_y      = 8'(y);
      cmd_radius = 3'(r);
      cmd_color  = 3'(col);
      cmd_valid  = 1'b1;
      while (!cmd_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (!cmd_ready) begin
         checks++; failures++;
         $display("FAIL send: cmd_ready stayed 0 for %0d cycles, required 1", w);
      end
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #2;
      checks++;
      if ({cmd_ready, busy, brush} !== 3'b100) begin
         failures++;
         $display("FAIL reset_ctl: ready/busy/brush=%b required 100", {cmd_ready, busy, brush});
      end
      checks++;
      if ({wx, wy, newColor} !== {8'd0, 8'd0, COL_ERASE}) begin
         failures++;
         $display("FAIL reset_out: wx=%0d wy=%0d color=%0d required 0 0 %0d", wx, wy, newColor, COL_ERASE);
      end
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({cmd_ready, busy, brush} !== 3'b100) begin
         failures++;
         $display("FAIL reset_idle: ready/busy/brush=%b required 100", {cmd_ready, busy, brush});
      end
   endtask

   // One stamp checked against a list built from the clipping rules.
   task automatic test_stamp(input string nm, input int x, input int y, input int r, input int col);
      int ex[$];
      int ey[$];
      int xlo, xhi, ylo, yhi, n, first, rdy, gap, exp_rdy;
      xlo = (x - r < 0) ? 0 : x - r;
      xhi = (x + r > 127) ? 127 : x + r;
      ylo = (y - r < 0) ? 0 : y - r;
      yhi = (y + r > 127) ? 127 : y + r;
      for (int yy = ylo; yy <= yhi; yy++)
         for (int xx = xlo; xx <= xhi; xx++) begin
            ex.push_back(xx);
            ey.push_back(yy);
         end
      send(1'b0, x, y, r, col);
      n = 0; first = -1; rdy = -1; gap = 0;
      for (int c = 1; c <= 600; c++) begin
         @(negedge clk);
         if (brush) begin
            if (first < 0) first = c;
            if (n < ex.size()) begin
               checks++;
               if ({wx, wy, newColor} !== {8'(ex[n]), 8'(ey[n]), 3'(col)}) begin
                  failures++;
                  $display("FAIL %s write%0d: got (%0d,%0d,c%0d) required (%0d,%0d,c%0d)",
                           nm, n, wx, wy, newColor, ex[n], ey[n], col);
               end
            end
            n++;
         end else if (n > 0 && !cmd_ready) gap++;
         if (cmd_ready) begin
            rdy = c;
            break;
         end
      end
      exp_rdy = (ex.size() == 0) ? 2 : ex.size() + 1;
      checks++;
      if (n !== ex.size()) begin
         failures++;
         $display("FAIL %s count: got %0d writes required %0d", nm, n, ex.size());
      end
      checks++;
      if (rdy !== exp_rdy) begin
         failures++;
         $display("FAIL %s ready_cycle: got %0d required %0d", nm, rdy, exp_rdy);
      end
      checks++;
      if (gap !== 0 || brush !== 1'b0) begin
         failures++;
         $display("FAIL %s continuity: gaps=%0d brush_at_ready=%b required 0 0", nm, gap, brush);
      end
      if (ex.size() > 0) begin
         checks++;
         if (first !== 1) begin
            failures++;
            $display("FAIL %s first_write_cycle: got %0d required 1", nm, first);
         end
      end
   endtask

   task automatic test_clear();
      int n, bad, first_bad, rdy;
      send(1'b1, 0, 0, 0, 0);
      // Second command held pending for the whole clear.
      cmd_clear = 1'b0; cmd_x = 8'd5; cmd_y = 8'd6; cmd_radius = 3'd0; cmd_color = COL_RED;
      cmd_valid = 1'b1;
      n = 0; bad = 0; first_bad = -1; rdy = -1;
      for (int c = 1; c <= 17000; c++) begin
         @(negedge clk);
         if (brush) begin
            if ({wx, wy, newColor} !== {8'(n % 128), 8'(n / 128), COL_ERASE} || cmd_ready) begin
               bad++;
               if (first_bad < 0) first_bad = n;
            end
            n++;
         end
         if (cmd_ready) begin
            rdy = c;
            break;
         end
      end
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL clear_seq: %0d bad writes (first at index %0d) required 0", bad, first_bad);
      end
      checks++;
      if (n !== 16384 || rdy !== 16385) begin
         failures++;
         $display("FAIL clear_count: writes=%0d ready_cycle=%0d required 16384 16385", n, rdy);
      end
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({brush, wx, wy, newColor} !== {1'b1, 8'd5, 8'd6, COL_RED}) begin
         failures++;
         $display("FAIL clear_pending: brush=%b (%0d,%0d,c%0d) required 1 (5,6,c%0d)",
                  brush, wx, wy, newColor, COL_RED);
      end
      @(negedge clk);
      checks++;
      if ({cmd_ready, brush} !== 2'b10) begin
         failures++;
         $display("FAIL clear_pending_done: ready/brush=%b required 10", {cmd_ready, brush});
      end
   endtask

   task automatic test_back_to_back();
      int n = 0, bubble = 0;
      send(1'b0, 30, 40, 1, COL_BLUE);
      for (int c = 1; c <= 50; c++) begin
         @(negedge clk);
         if (brush) n++;
         else bubble++;
         if (cmd_ready) break;
      end
      // Present the next command the moment ready is seen.
      cmd_x = 8'd100; cmd_y = 8'd101; cmd_radius = 3'd0; cmd_color = COL_WHITE; cmd_valid = 1'b1;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (n !== 9 || bubble !== 1) begin
         failures++;
         $display("FAIL b2b_first: writes=%0d bubble=%0d required 9 1", n, bubble);
      end
      checks++;
      if ({brush, wx, wy, newColor} !== {1'b1, 8'd100, 8'd101, COL_WHITE}) begin
         failures++;
         $display("FAIL b2b_second: brush=%b (%0d,%0d,c%0d) required 1 (100,101,c%0d)",
                  brush, wx, wy, newColor, COL_WHITE);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_abort();
      int n = 0, late = 0;
      send(1'b0, 60, 60, 2, COL_BLUE);
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (brush) n++;
         if (n == 4) break;
      end
      checks++;
      if ({n[7:0], wx, wy} !== {8'd4, 8'd61, 8'd58}) begin
         failures++;
         $display("FAIL abort_4th: n=%0d at (%0d,%0d) required 4 at (61,58)", n, wx, wy);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({brush, cmd_ready, busy} !== 3'b010) begin
         failures++;
         $display("FAIL abort_immediate: brush/ready/busy=%b required 010", {brush, cmd_ready, busy});
      end
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (brush || !cmd_ready) late++;
      end
      checks++;
      if (late !== 0) begin
         failures++;
         $display("FAIL abort_after: %0d cycles with writes or busy, required 0", late);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 12; i++)
         test_stamp("random", int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      for (int i = 0; i < 6; i++)
         test_stamp("random_edge", int'($urandom_range(120, 135)), int'($urandom_range(0, 8)),
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
   endtask

   initial begin
      cmd_valid = 1'b0; cmd_clear = 1'b0; cmd_x = '0; cmd_y = '0;
      cmd_color = '0; cmd_radius = '0; reset = 1'b0;
      @(negedge clk);
      test_reset();
      test_stamp("basic", 10, 20, 1, COL_GREEN);
      test_stamp("corner", 0, 0, 2, COL_RED);
      test_stamp("far_edge", 127, 127, 3, COL_BLUE);
      test_stamp("null", 200, 5, 2, COL_WHITE);
      test_stamp("r0_in", 127, 0, 0, COL_GREEN);
      test_stamp("r0_out", 128, 3, 0, COL_GREEN);
      test_back_to_back();
      test_clear();
      test_reset_abort();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
